// File: rtl/nand_flash_responder.sv
// nand_flash_responder: NAND device model with page read, page program (AND-only) and block erase.
// Optional write protect input wp_n is enabled by defining NAND_WP_EN.
module nand_flash_responder #(
  parameter int ROW_ADDR_WIDTH = 6,
  parameter int COL_ADDR_WIDTH = 4,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int BLOCK_LEN = 8,
  parameter int BLOCK_NUM = 8,
  parameter int T_READ = 4,
  parameter int T_PROG = 20,
  parameter int T_ERASE = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [ROW_ADDR_WIDTH-1:0] cmd_row,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [MEM_DATA_WIDTH-1:0] wr_data,
  output logic rd_valid,
  input  logic rd_ready,
  output logic [MEM_DATA_WIDTH-1:0] rd_data,
  output logic rd_last,
  output logic busy,
`ifdef NAND_WP_EN
  input  logic wp_n,
`endif
  output logic status_fail
);
  localparam int RW = ROW_ADDR_WIDTH;
  localparam int CWD = COL_ADDR_WIDTH;
  localparam int AW = RW + CWD;
  localparam int N = 2 ** CWD;
  localparam int NR = 2 ** RW;
  localparam int LB = $clog2(BLOCK_LEN);
  localparam int EW = CWD + LB;
  localparam int TW = $clog2(T_ERASE + T_PROG + T_READ + 2);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_XFER, PG_LOAD, PG_WAIT, ER_WAIT} state_t;
  state_t state, nxt;
  // Power-up contents of a fresh device: all words erased, no page programmed.
  logic [MEM_DATA_WIDTH-1:0] mem [2**AW] = '{default: '1};
  logic [NR-1:0] prog = '0;
  logic [RW-1:0] row;
  logic [CWD-1:0] col, coln;
  logic [TW-1:0] cnt;
  logic [NR-1:0] bmask;
  logic ign, acc, ok, wp, rd_hs, wr_hs;
`ifdef NAND_WP_EN
  assign wp = !wp_n;
`else
  assign wp = 1'b0;
`endif
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign wr_ready = state == PG_LOAD;
  assign rd_valid = state == RD_XFER;
  assign rd_last = rd_valid && col == CWD'(N - 1);
  assign acc = cmd_valid && cmd_ready;
  assign rd_hs = rd_valid && rd_ready;
  assign wr_hs = wr_valid && wr_ready;
  assign coln = col + CWD'(1);
  assign ok = ({1'b0, cmd_row} < (RW + 1)'(BLOCK_NUM * BLOCK_LEN)) && cmd_op != 2'b11 && !(wp && cmd_op != 2'b00);
  assign bmask = NR'({BLOCK_LEN{1'b1}}) << {cmd_row[RW-1:LB], LB'(0)};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc && ok) nxt = cmd_op == 2'b00 ? RD_WAIT : cmd_op == 2'b01 ? PG_LOAD : ER_WAIT;
      RD_WAIT: if (cnt == TW'(T_READ - 1)) nxt = RD_XFER;
      RD_XFER: if (rd_hs && col == CWD'(N - 1)) nxt = IDLE;
      PG_LOAD: if (wr_hs && col == CWD'(N - 1)) nxt = PG_WAIT;
      PG_WAIT: if (cnt == TW'(T_PROG - 1)) nxt = IDLE;
      ER_WAIT: if (cnt == TW'(T_ERASE - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      col <= '0;
      row <= '0;
      ign <= 1'b0;
      rd_data <= '0;
      status_fail <= 1'b0;
    end else begin
      cnt <= (state == nxt && state != IDLE) ? cnt + TW'(1) : '0;
      if (acc) begin
        row <= cmd_row;
        col <= '0;
        ign <= prog[cmd_row];
        status_fail <= !ok;
      end else if (rd_hs || wr_hs) col <= coln;
      if (state == RD_WAIT && nxt == RD_XFER) rd_data <= mem[{row, CWD'(0)}];
      else if (rd_hs) rd_data <= mem[{row, coln}];
      if (state == PG_WAIT && nxt == IDLE) status_fail <= ign;
    end
  end
  // Array and programmed flags survive rst so partial operations stay visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_hs && !ign) mem[{row, col}] <= mem[{row, col}] & wr_data;
      if (state == ER_WAIT && cnt < TW'(BLOCK_LEN * N)) mem[{row[RW-1:LB], cnt[EW-1:0]}] <= '1;
      if (acc && ok && cmd_op == 2'b01) prog[cmd_row] <= 1'b1;
      if (acc && ok && cmd_op == 2'b10) prog <= prog & ~bmask;
    end
  end
endmodule

// File: tb/tb_nand_flash_responder.sv
// tb_nand_flash_responder: scoreboard bench; read beats are checked against a queue filled from a bench-side array model.
module tb_nand_flash_responder;
  localparam int N = 16, BL = 8, TR = 4, TP = 20, TE = 200;
  logic clk = 0, rst = 1, cmd_valid = 0, wr_valid = 0, rd_ready = 0, wp_n = 1;
  logic [1:0] cmd_op = 0;
  logic [5:0] cmd_row = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic cmd_ready, wr_ready, rd_valid, rd_last, busy, status_fail;
  logic [7:0] model [1024];
  bit pf [64];
  logic [7:0] q [$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  nand_flash_responder #(
    .ROW_ADDR_WIDTH(6), .COL_ADDR_WIDTH(4), .MEM_DATA_WIDTH(8), .BLOCK_LEN(BL), .BLOCK_NUM(8),
    .T_READ(TR), .T_PROG(TP), .T_ERASE(TE)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_row(cmd_row),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
`ifdef NAND_WP_EN
    .wp_n(wp_n),
`endif
    .status_fail(status_fail)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [5:0] row);
    int n = 0;
    while (!cmd_ready && n < 500) begin tick(); n++; end
    chk("cmd_ready", cmd_ready, 1);
    cmd_op = op;
    cmd_row = row;
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
  endtask
  task automatic rd(input logic [5:0] row, input bit tog, input int abort);
    int n = 0, beats = 0, cyc = 0;
    for (int c = 0; c < N; c++) q.push_back(model[{row, 4'(c)}]);
    issue(2'b00, row);
    chk("rd_busy", busy, 1);
    while (!rd_valid && n < 50) begin n++; tick(); end
    chk("rd_latency", n, TR);
    rd_ready = 1;
    while (beats < N && cyc < 200) begin
      if (beats == abort) begin
        rst = 1;
        tick();
        rst = 0;
        rd_ready = 0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        q.delete();
        return;
      end
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, q.pop_front());
        chk("rd_last", rd_last, beats == N - 1);
        beats++;
      end else if (rd_valid) chk("rd_hold", rd_data, q[0]);
      tick();
      cyc++;
      if (tog) rd_ready = ~rd_ready;
    end
    rd_ready = 0;
    chk("rd_beats", beats, N);
    chk("rd_done_busy", busy, 0);
    chk("rd_fail", status_fail, 0);
  endtask
  task automatic pg(input logic [5:0] row, input logic [7:0] mul, input logic [7:0] add);
    bit f = pf[row];
    int n = 0;
    logic [7:0] d;
    issue(2'b01, row);
    chk("wr_ready", wr_ready, 1);
    for (int c = 0; c < N; c++) begin
      d = 8'(mul * c) + add;
      wr_data = d;
      wr_valid = 1;
      if (!f) model[{row, 4'(c)}] = model[{row, 4'(c)}] & d;
      tick();
    end
    wr_valid = 0;
    pf[row] = 1;
    while (busy && n < 100) begin n++; tick(); end
    chk("pg_busy", n, TP);
    chk("pg_fail", status_fail, f);
  endtask
  task automatic er(input logic [5:0] row);
    int n = 0;
    for (int i = 0; i < BL * N; i++) model[{row[5:3], 7'(i)}] = 8'hFF;
    for (int i = 0; i < BL; i++) pf[{row[5:3], 3'(i)}] = 0;
    issue(2'b10, row);
    while (busy && n < 400) begin n++; tick(); end
    chk("er_busy", n, TE);
    chk("er_fail", status_fail, 0);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 8'hFF;
    for (int i = 0; i < 64; i++) pf[i] = 0;
    tick();
    tick();
    rst = 0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_fail", status_fail, 0);
    rd(6'd5, 0, 99);
    pg(6'd9, 8'd3, 8'd0);
    rd(6'd9, 0, 99);
    pg(6'd9, 8'd0, 8'hF0);
    rd(6'd9, 0, 99);
    er(6'd8);
    pg(6'd9, 8'd0, 8'hF0);
    rd(6'd9, 0, 99);
    for (int r = 16; r <= 24; r++) pg(6'(r), 8'd5, 8'(r));
    er(6'd19);
    for (int r = 16; r <= 24; r++) rd(6'(r), 0, 99);
    issue(2'b11, 6'd0);
    chk("inv_busy", busy, 0);
    chk("inv_fail", status_fail, 1);
    rd(6'd24, 1, 99);
    rd(6'd24, 1, 7);
    rd(6'd9, 1, 99);
`ifdef NAND_WP_EN
    wp_n = 0;
    issue(2'b01, 6'd2);
    chk("wp_busy", busy, 0);
    chk("wp_wr_ready", wr_ready, 0);
    chk("wp_fail", status_fail, 1);
    issue(2'b10, 6'd9);
    chk("wp_er_busy", busy, 0);
    chk("wp_er_fail", status_fail, 1);
    rd(6'd2, 0, 99);
    rd(6'd9, 0, 99);
    wp_n = 1;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
